rst_sequencer: RTL

- Sits directly downstream of the board clock/reset infrastructure block.
- Consumes the system clock, the system reset and the asynchronous IDELAYCTRL ready flag.
- Produces NUM_STAGES staged active-high resets for downstream domains (e.g. ADC/IDELAY capture, DSP, bus interface), released one at a time in order once the delay controller is stable.
- Re-asserts all stages on loss of ready or on software request, then re-runs the sequence.

---
 rtl/rst_sequencer_if.sv | 24 ++
 rtl/rst_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer_if.sv
// Signal bundle between the reset sequencer and the domains it controls.
// master = the sequencer, slave = the environment feeding ready/request and consuming resets.
interface rst_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  logic                  idelay_rdy;
  logic                  sw_rst_req;
  logic [NUM_STAGES-1:0] stage_rst;
  logic                  seq_done;
  logic [2:0]            seq_state;
  logic [7:0]            fault_count;
  logic                  idelay_rst_req;
  logic                  timeout;

  modport master (
    input  idelay_rdy, sw_rst_req,
    output stage_rst, seq_done, seq_state, fault_count, idelay_rst_req, timeout
  );

  modport slave (
    output idelay_rdy, sw_rst_req,
    input  stage_rst, seq_done, seq_state, fault_count, idelay_rst_req, timeout
  );
endinterface

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: releases NUM_STAGES resets in order once IDELAYCTRL ready is stable.
// Optional WAIT_RDY watchdog toward IDELAYCTRL is enabled by defining RST_SEQ_TIMEOUT_EN.
module rst_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int STAGE_DELAY    = 256,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic sys_clk,
  input  logic sys_rst,
  rst_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    RESET    = 3'd0,
    WAIT_RDY = 3'd1,
    SETTLE   = 3'd2,
    RELEASE  = 3'd3,
    RUN      = 3'd4,
    FAULT    = 3'd5
  } state_t;

  localparam int CNT_MAX = (SETTLE_CYCLES > STAGE_DELAY) ? SETTLE_CYCLES : STAGE_DELAY;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_num_stages
    $error("rst_sequencer: NUM_STAGES out of range 1..16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("rst_sequencer: SYNC_STAGES out of range 2..4");
  end
  if (STAGE_DELAY < 1 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_delays
    $error("rst_sequencer: STAGE_DELAY, SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] rdy_sync;
  logic                   rdy_s;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [NUM_STAGES-1:0]  stage_rst, stage_rst_nxt;
  logic                   seq_done, seq_done_nxt;
  logic [7:0]             fault_count, fault_count_nxt;
  logic                   rdy_loss, sw_req;

  assign rdy_s = rdy_sync[SYNC_STAGES-1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rdy_sync    <= '0;
      state       <= RESET;
      cnt         <= '0;
      idx         <= '0;
      stage_rst   <= '1;
      seq_done    <= 1'b0;
      fault_count <= 8'd0;
    end else begin
      rdy_sync    <= {rdy_sync[SYNC_STAGES-2:0], bus.idelay_rdy};
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      stage_rst   <= stage_rst_nxt;
      seq_done    <= seq_done_nxt;
      fault_count <= fault_count_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    idx_nxt         = idx;
    stage_rst_nxt   = stage_rst;
    seq_done_nxt    = seq_done;
    fault_count_nxt = fault_count;
    rdy_loss = !rdy_s && (state == RELEASE || state == RUN);
    sw_req   = bus.sw_rst_req && (state != RESET) && (state != FAULT);

    // Ready loss and software request share one path; only ready loss is counted.
    if (rdy_loss || sw_req) begin
      state_nxt     = FAULT;
      cnt_nxt       = '0;
      stage_rst_nxt = '1;
      seq_done_nxt  = 1'b0;
      if (rdy_loss) fault_count_nxt = sat_inc8(fault_count);
    end else begin
      case (state)
        RESET: begin
          state_nxt     = WAIT_RDY;
          stage_rst_nxt = '1;
          seq_done_nxt  = 1'b0;
        end
        WAIT_RDY: begin
          stage_rst_nxt = '1;
          if (rdy_s) begin
            cnt_nxt   = '0;
            state_nxt = SETTLE;
          end
        end
        SETTLE: begin
          if (!rdy_s) begin
            state_nxt = WAIT_RDY;
          end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt_nxt   = '0;
            idx_nxt   = '0;
            state_nxt = RELEASE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == CNT_W'(STAGE_DELAY - 1)) begin
            stage_rst_nxt[idx] = 1'b0;
            cnt_nxt            = '0;
            if (idx == IDX_W'(NUM_STAGES - 1)) begin
              idx_nxt      = '0;
              state_nxt    = RUN;
              seq_done_nxt = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RUN: begin
          stage_rst_nxt = '0;
          seq_done_nxt  = 1'b1;
        end
        FAULT: begin
          stage_rst_nxt = '1;
          if (bus.sw_rst_req) begin
            cnt_nxt = '0;
          end else if (cnt == CNT_W'(STAGE_DELAY - 1)) begin
            cnt_nxt   = '0;
            state_nxt = WAIT_RDY;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt     = RESET;
          stage_rst_nxt = '1;
          seq_done_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign bus.stage_rst   = stage_rst;
  assign bus.seq_done    = seq_done;
  assign bus.seq_state   = state;
  assign bus.fault_count = fault_count;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
  logic [3:0]      pulse_cnt, pulse_cnt_nxt;
  logic            idelay_rst_req, idelay_rst_req_nxt;
  logic            timeout, timeout_nxt;
  logic            wd_stay, wd_trig;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wd_cnt         <= '0;
      pulse_cnt      <= '0;
      idelay_rst_req <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      wd_cnt         <= wd_cnt_nxt;
      pulse_cnt      <= pulse_cnt_nxt;
      idelay_rst_req <= idelay_rst_req_nxt;
      timeout        <= timeout_nxt;
    end
  end

  // Watchdog only runs while the FSM stays in WAIT_RDY; the 16-cycle pulse runs to completion.
  always_comb begin
    pulse_cnt_nxt      = pulse_cnt;
    idelay_rst_req_nxt = idelay_rst_req;
    timeout_nxt        = timeout;
    wd_stay    = (state == WAIT_RDY) && (state_nxt == WAIT_RDY);
    wd_trig    = wd_stay && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    wd_cnt_nxt = (wd_stay && !wd_trig) ? wd_cnt + 1'b1 : '0;
    if (wd_trig) begin
      idelay_rst_req_nxt = 1'b1;
      pulse_cnt_nxt      = 4'd15;
      timeout_nxt        = 1'b1;
    end else if (idelay_rst_req) begin
      if (pulse_cnt == 4'd0) idelay_rst_req_nxt = 1'b0;
      else                   pulse_cnt_nxt      = pulse_cnt - 4'd1;
    end
  end

  assign bus.idelay_rst_req = idelay_rst_req;
  assign bus.timeout        = timeout;
`else
  assign bus.idelay_rst_req = 1'b0;
  assign bus.timeout        = 1'b0;
`endif

endmodule
